// File: rtl/gearbox_24_32_if.sv
// Stream bundle for the 24->32 gearbox: 3-byte words in, 4-byte words out.
// The master drives the 24-bit input stream; the slave (the gearbox) drives the packed output.
interface gearbox_24_32_if;
   logic [23:0] data_in;
   logic        data_en;
   logic        data_in_last;
   logic        data_in_rdy;
   logic [31:0] data_out;
   logic        data_out_en;
   logic        data_out_last;
   logic [3:0]  data_out_keep;

   modport master (
      output data_in, data_en, data_in_last,
      input  data_in_rdy, data_out, data_out_en, data_out_last, data_out_keep
   );

   modport slave (
      input  data_in, data_en, data_in_last,
      output data_in_rdy, data_out, data_out_en, data_out_last, data_out_keep
   );
endinterface

// File: rtl/gearbox_24_32.sv
// Packs 3-byte words into 4-byte words (4 in -> 3 out); a frame ending mid-word
// is closed with a PAD_BYTE-filled final word and a byte-valid mask.
module gearbox_24_32 #(
   parameter logic [7:0] PAD_BYTE = 8'h00
) (
   input logic            clk_in,
   input logic            reset_n,
   gearbox_24_32_if.slave bus
);

   // Number of residue bytes currently held, left-aligned in res_q.
   typedef enum logic [1:0] {
      CNT0 = 2'd0,
      CNT1 = 2'd1,
      CNT2 = 2'd2,
      CNT3 = 2'd3
   } cnt_e;

   cnt_e        cnt_q, cnt_d;
   logic [23:0] res_q, res_d;
   logic        flush_q, flush_d;
   logic [31:0] out_q, out_d;
   logic        oen_q, oen_d;
   logic        olast_q, olast_d;
   logic [3:0]  keep_q, keep_d;
   logic        accept;

   assign accept = bus.data_en & ~flush_q;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= CNT0;
         res_q   <= '0;
         flush_q <= 1'b0;
         out_q   <= '0;
         oen_q   <= 1'b0;
         olast_q <= 1'b0;
         keep_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         flush_q <= flush_d;
         out_q   <= out_d;
         oen_q   <= oen_d;
         olast_q <= olast_d;
         keep_q  <= keep_d;
      end
   end

   // A last word arriving with 3 or 2 residue bytes follows the normal transition,
   // so the remainder lands in res_q and cnt_q tells the flush how many bytes it owns.
   always_comb begin
      cnt_d   = cnt_q;
      res_d   = res_q;
      flush_d = flush_q;
      out_d   = out_q;
      oen_d   = 1'b0;
      olast_d = 1'b0;
      keep_d  = keep_q;
      if (flush_q) begin
         oen_d   = 1'b1;
         olast_d = 1'b1;
         flush_d = 1'b0;
         cnt_d   = CNT0;
         if (cnt_q == CNT2) begin
            out_d  = {res_q[23:8], PAD_BYTE, PAD_BYTE};
            keep_d = 4'hC;
         end else begin
            out_d  = {res_q[23:16], {3{PAD_BYTE}}};
            keep_d = 4'h8;
         end
      end else if (accept) begin
         unique case (cnt_q)
            CNT0: begin
               if (bus.data_in_last) begin
                  out_d   = {bus.data_in, PAD_BYTE};
                  keep_d  = 4'hE;
                  oen_d   = 1'b1;
                  olast_d = 1'b1;
               end else begin
                  res_d = bus.data_in;
                  cnt_d = CNT3;
               end
            end
            CNT3: begin
               out_d       = {res_q, bus.data_in[23:16]};
               keep_d      = 4'hF;
               oen_d       = 1'b1;
               res_d[23:8] = bus.data_in[15:0];
               cnt_d       = CNT2;
               flush_d     = bus.data_in_last;
            end
            CNT2: begin
               out_d        = {res_q[23:8], bus.data_in[23:8]};
               keep_d       = 4'hF;
               oen_d        = 1'b1;
               res_d[23:16] = bus.data_in[7:0];
               cnt_d        = CNT1;
               flush_d      = bus.data_in_last;
            end
            CNT1: begin
               out_d   = {res_q[23:16], bus.data_in};
               keep_d  = 4'hF;
               oen_d   = 1'b1;
               olast_d = bus.data_in_last;
               cnt_d   = CNT0;
            end
            default: cnt_d = CNT0;
         endcase
      end
   end

   assign bus.data_in_rdy   = ~flush_q;
   assign bus.data_out      = out_q;
   assign bus.data_out_en   = oen_q;
   assign bus.data_out_last = olast_q;
   assign bus.data_out_keep = keep_q;

endmodule

// File: tb/tb_gearbox_24_32.sv
// Bench for gearbox_24_32: directed vector table, reset-mid-frame sequence and
// random traffic against a byte-queue reference model; two instances cover PAD_BYTE 00/FF.
module tb_gearbox_24_32;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] din = '0;
   logic        den = 1'b0;
   logic        dlast = 1'b0;
   int          tests = 0;
   int          fails = 0;

   gearbox_24_32_if b0 ();
   gearbox_24_32_if b1 ();

   assign b0.data_in      = din;
   assign b0.data_en      = den;
   assign b0.data_in_last = dlast;
   assign b1.data_in      = din;
   assign b1.data_en      = den;
   assign b1.data_in_last = dlast;

   gearbox_24_32 #(.PAD_BYTE(8'h00)) dut0 (.clk_in(clk), .reset_n(rst_n), .bus(b0));
   gearbox_24_32 #(.PAD_BYTE(8'hFF)) dut1 (.clk_in(clk), .reset_n(rst_n), .bus(b1));

   always #5 clk = ~clk;

   // Reference model: a plain byte FIFO plus a "flush owed next cycle" flag.
   logic [7:0]  q[$];
   bit          mflush = 1'b0;
   logic        me, ml;
   logic [3:0]  mk;
   logic [31:0] mo, mff;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic emit_partial();
      int n;
      n  = q.size();
      mo = '0;
      for (int i = 0; i < n; i++) mo[31-8*i -: 8] = q[i];
      mk = 4'(4'hF << (4 - n));
      me = 1'b1;
      ml = 1'b1;
      q.delete();
   endtask

   task automatic model_edge(input logic en, input logic last, input logic [23:0] d);
      me = 1'b0; ml = 1'b0; mk = '0; mo = '0;
      if (mflush) begin
         emit_partial();
         mflush = 1'b0;
      end else if (en) begin
         q.push_back(d[23:16]);
         q.push_back(d[15:8]);
         q.push_back(d[7:0]);
         if (q.size() >= 4) begin
            for (int i = 0; i < 4; i++) mo[31-8*i -: 8] = q.pop_front();
            mk = 4'hF;
            me = 1'b1;
         end
         if (last) begin
            if (q.size() == 0) ml = 1'b1;
            else if (me)       mflush = 1'b1;
            else               emit_partial();
         end
      end
      mff = mo;
      for (int b = 0; b < 4; b++) if (!mk[b]) mff[8*b +: 8] = 8'hFF;
   endtask

   task automatic step(input logic en, input logic last, input logic [23:0] d);
      din = d; den = en; dlast = last;
      chk("rdy0", 32'(b0.data_in_rdy), 32'(!mflush));
      chk("rdy1", 32'(b1.data_in_rdy), 32'(!mflush));
      model_edge(en, last, d);
      @(posedge clk); #1;
      chk("oen0", 32'(b0.data_out_en), 32'(me));
      chk("oen1", 32'(b1.data_out_en), 32'(me));
      if (me) begin
         chk("data0", b0.data_out, mo);
         chk("last0", 32'(b0.data_out_last), 32'(ml));
         chk("keep0", 32'(b0.data_out_keep), 32'(mk));
         chk("data1", b1.data_out, mff);
         chk("last1", 32'(b1.data_out_last), 32'(ml));
         chk("keep1", 32'(b1.data_out_keep), 32'(mk));
      end else begin
         chk("last0_idle", 32'(b0.data_out_last), 32'd0);
         chk("last1_idle", 32'(b1.data_out_last), 32'd0);
      end
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_data0"}, b0.data_out, 32'h0);
      chk({nm, "_en0"},   32'(b0.data_out_en), 32'h0);
      chk({nm, "_last0"}, 32'(b0.data_out_last), 32'h0);
      chk({nm, "_keep0"}, 32'(b0.data_out_keep), 32'h0);
      chk({nm, "_rdy0"},  32'(b0.data_in_rdy), 32'h1);
      chk({nm, "_data1"}, b1.data_out, 32'h0);
      chk({nm, "_en1"},   32'(b1.data_out_en), 32'h0);
   endtask

   typedef struct {
      logic        en, last;
      logic [23:0] d;
      logic        rdy, oen, olast;
      logic [3:0]  keep;
      logic [31:0] out, ff;
   } vec_t;

   function automatic vec_t mkv(logic en, logic last, logic [23:0] d, logic rdy,
                                logic oen, logic olast, logic [3:0] keep,
                                logic [31:0] out, logic [31:0] ff);
      vec_t v;
      v.en = en; v.last = last; v.d = d; v.rdy = rdy; v.oen = oen;
      v.olast = olast; v.keep = keep; v.out = out; v.ff = ff;
      return v;
   endfunction

   localparam logic [23:0] A = 24'h112233, B = 24'h445566, C = 24'h778899, D = 24'hAABBCC;

   initial begin
      vec_t tbl[$];
      // full-word frame
      tbl.push_back(mkv(1, 0, A, 1, 0, 0, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mkv(1, 0, B, 1, 1, 0, 4'hF, 32'h11223344, 32'h11223344));
      tbl.push_back(mkv(1, 0, C, 1, 1, 0, 4'hF, 32'h55667788, 32'h55667788));
      tbl.push_back(mkv(1, 1, D, 1, 1, 1, 4'hF, 32'h99AABBCC, 32'h99AABBCC));
      // single-word frame
      tbl.push_back(mkv(1, 1, A, 1, 1, 1, 4'hE, 32'h11223300, 32'h112233FF));
      // two-word frame, C during flush is ignored
      tbl.push_back(mkv(1, 0, A, 1, 0, 0, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mkv(1, 1, B, 1, 1, 0, 4'hF, 32'h11223344, 32'h11223344));
      tbl.push_back(mkv(1, 0, C, 0, 1, 1, 4'hC, 32'h55660000, 32'h5566FFFF));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0));
      // three-word frame
      tbl.push_back(mkv(1, 0, A, 1, 0, 0, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mkv(1, 0, B, 1, 1, 0, 4'hF, 32'h11223344, 32'h11223344));
      tbl.push_back(mkv(1, 1, C, 1, 1, 0, 4'hF, 32'h55667788, 32'h55667788));
      tbl.push_back(mkv(0, 0, 0, 0, 1, 1, 4'h8, 32'h99000000, 32'h99FFFFFF));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0));
      // intermittent full-word frame
      tbl.push_back(mkv(1, 0, A, 1, 0, 0, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mkv(1, 0, B, 1, 1, 0, 4'hF, 32'h11223344, 32'h11223344));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mkv(1, 0, C, 1, 1, 0, 4'hF, 32'h55667788, 32'h55667788));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0));
      tbl.push_back(mkv(1, 1, D, 1, 1, 1, 4'hF, 32'h99AABBCC, 32'h99AABBCC));
      tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 4'h0, 32'h0, 32'h0));

      #1;
      chk_reset_outputs("reset_async");
      @(posedge clk); #1;
      chk_reset_outputs("reset_held");
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         chk($sformatf("tbl%0d_rdy", i), 32'(b0.data_in_rdy), 32'(tbl[i].rdy));
         step(tbl[i].en, tbl[i].last, tbl[i].d);
         chk($sformatf("tbl%0d_oen", i), 32'(b0.data_out_en), 32'(tbl[i].oen));
         if (tbl[i].oen) begin
            chk($sformatf("tbl%0d_out", i),  b0.data_out, tbl[i].out);
            chk($sformatf("tbl%0d_last", i), 32'(b0.data_out_last), 32'(tbl[i].olast));
            chk($sformatf("tbl%0d_keep", i), 32'(b0.data_out_keep), 32'(tbl[i].keep));
            chk($sformatf("tbl%0d_ff", i),   b1.data_out, tbl[i].ff);
         end
      end

      // reset in the middle of a frame drops the residue
      step(1, 0, A);
      step(1, 0, B);
      chk("rst_pre_out", b0.data_out, 32'h11223344);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      q.delete();
      mflush = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs("rst_mid_held");
      rst_n = 1'b1;
      step(1, 0, C);
      chk("rst_c_noout", 32'(b0.data_out_en), 32'h0);
      step(1, 0, D);
      chk("rst_w1", b0.data_out, 32'h778899AA);
      step(1, 1, A);
      chk("rst_w2", b0.data_out, 32'hBBCC1122);
      chk("rst_w2_last", 32'(b0.data_out_last), 32'h0);
      step(0, 0, 0);
      chk("rst_w3", b0.data_out, 32'h33000000);
      chk("rst_w3_keep", 32'(b0.data_out_keep), 32'h8);
      chk("rst_w3_last", 32'(b0.data_out_last), 32'h1);

      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 24'($urandom));
      step(0, 0, 0);
      step(0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
